rob_commit_queue: RTL

ROB_COMMIT_QUEUE -- requirements
Module: rob_commit_queue

---
 rtl/rob_commit_queue_if.sv | 49 ++++
 rtl/rob_commit_queue.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/rob_commit_queue_if.sv
// Signal bundle between decode/execute/regfile and the reorder-buffer commit queue.
// The ROB itself takes the slave modport.
interface rob_commit_queue_if;
   logic        alloc_req;
   logic [4:0]  alloc_rd;
   logic        alloc_wen;
   logic        alloc_ready;
   logic [4:0]  alloc_roben;

   logic        cdb_valid;
   logic [4:0]  cdb_roben;
   logic [31:0] cdb_data;

   logic [4:0]  rd1_roben;
   logic [4:0]  rd2_roben;
   logic        rd1_ready;
   logic        rd2_ready;
   logic [31:0] rd1_data;
   logic [31:0] rd2_data;

   logic        commit_wen;
   logic [4:0]  commit_roben;
   logic [4:0]  commit_rd;
   logic [31:0] commit_data;

   logic        empty;
   logic        full;
   logic [3:0]  count;

   modport master (
      output alloc_req, alloc_rd, alloc_wen,
      output cdb_valid, cdb_roben, cdb_data,
      output rd1_roben, rd2_roben,
      input  alloc_ready, alloc_roben,
      input  rd1_ready, rd2_ready, rd1_data, rd2_data,
      input  commit_wen, commit_roben, commit_rd, commit_data,
      input  empty, full, count
   );

   modport slave (
      input  alloc_req, alloc_rd, alloc_wen,
      input  cdb_valid, cdb_roben, cdb_data,
      input  rd1_roben, rd2_roben,
      output alloc_ready, alloc_roben,
      output rd1_ready, rd2_ready, rd1_data, rd2_data,
      output commit_wen, commit_roben, commit_rd, commit_data,
      output empty, full, count
   );
endinterface

// File: rtl/rob_commit_queue.sv
// In-order reorder buffer: allocates tags 1..N_ENTRIES at the tail, captures CDB results,
// forwards operands to decode and retires one ready head entry per cycle.
module rob_commit_queue #(
   parameter int N_ENTRIES = 15
) (
   input logic               clk,
   input logic               rst,
   rob_commit_queue_if.slave bus
);
   localparam logic [4:0] LAST_TAG = 5'(N_ENTRIES);
   localparam logic [3:0] CAPACITY = 4'(N_ENTRIES);

   logic [4:0]  head_reg;
   logic [4:0]  tail_reg;
   logic [3:0]  count_reg;
   logic        empty_reg;
   logic        full_reg;
   logic        commit_wen_reg;
   logic [4:0]  commit_roben_reg;
   logic [4:0]  commit_rd_reg;
   logic [31:0] commit_data_reg;

   logic        alloc_ready;
   logic        alloc_fire;
   logic        commit_fire;
   logic [4:0]  head_next;
   logic [4:0]  tail_next;
   logic [3:0]  count_next;

   // Per-entry OR chains: {busy, ready, wen, rd, data} of the head, and {ready, data} per lookup port.
   logic [N_ENTRIES:0][39:0] head_acc;
   logic [N_ENTRIES:0][32:0] rd1_acc;
   logic [N_ENTRIES:0][32:0] rd2_acc;

   logic        head_busy;
   logic        head_ready;
   logic        head_wen;
   logic [4:0]  head_rd;
   logic [31:0] head_data;

   assign head_acc[0] = '0;
   assign rd1_acc[0]  = '0;
   assign rd2_acc[0]  = '0;

   assign alloc_ready = (count_reg < CAPACITY);
   assign alloc_fire  = bus.alloc_req && alloc_ready;
   assign {head_busy, head_ready, head_wen, head_rd, head_data} = head_acc[N_ENTRIES];
   assign commit_fire = head_busy && head_ready;

   assign head_next = (head_reg == LAST_TAG) ? 5'd1 : head_reg + 5'd1;
   assign tail_next = (tail_reg == LAST_TAG) ? 5'd1 : tail_reg + 5'd1;

   always_comb begin
      count_next = count_reg;
      case ({alloc_fire, commit_fire})
         2'b10:   count_next = count_reg + 4'd1;
         2'b01:   count_next = count_reg - 4'd1;
         default: count_next = count_reg;
      endcase
   end

   genvar gi;
   generate
      for (gi = 1; gi <= N_ENTRIES; gi++) begin : g_entry
         localparam logic [4:0] TAG = 5'(gi);
         logic        busy_reg;
         logic        ready_reg;
         logic        wen_reg;
         logic [4:0]  rd_reg;
         logic [31:0] data_reg;

         // Allocation and commit never target the same entry: the tail slot is free unless the queue is full.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               busy_reg  <= 1'b0;
               ready_reg <= 1'b0;
               wen_reg   <= 1'b0;
               rd_reg    <= 5'd0;
               data_reg  <= 32'd0;
            end else if (alloc_fire && tail_reg == TAG) begin
               busy_reg  <= 1'b1;
               ready_reg <= 1'b0;
               wen_reg   <= bus.alloc_wen;
               rd_reg    <= bus.alloc_rd;
               data_reg  <= 32'd0;
            end else if (commit_fire && head_reg == TAG) begin
               busy_reg  <= 1'b0;
               ready_reg <= 1'b0;
               wen_reg   <= 1'b0;
               rd_reg    <= 5'd0;
               data_reg  <= 32'd0;
            end else if (bus.cdb_valid && bus.cdb_roben == TAG && busy_reg) begin
               ready_reg <= 1'b1;
               data_reg  <= bus.cdb_data;
            end
         end

         assign head_acc[gi] = head_acc[gi-1] |
            ((head_reg == TAG) ? {busy_reg, ready_reg, wen_reg, rd_reg, data_reg} : 40'd0);
         assign rd1_acc[gi] = rd1_acc[gi-1] |
            ((bus.rd1_roben == TAG && busy_reg && ready_reg) ? {1'b1, data_reg} : 33'd0);
         assign rd2_acc[gi] = rd2_acc[gi-1] |
            ((bus.rd2_roben == TAG && busy_reg && ready_reg) ? {1'b1, data_reg} : 33'd0);
      end
   endgenerate

   // Tag 0 is an architectural value; a live CDB broadcast wins over whatever is stored.
   function automatic logic [32:0] resolve(input logic [4:0] tag, input logic [32:0] stored,
                                           input logic cdb_v, input logic [4:0] cdb_tag,
                                           input logic [31:0] cdb_d);
      if (tag == 5'd0)
         return {1'b1, 32'd0};
      if (cdb_v && cdb_tag == tag)
         return {1'b1, cdb_d};
      return stored;
   endfunction

   assign {bus.rd1_ready, bus.rd1_data} =
      resolve(bus.rd1_roben, rd1_acc[N_ENTRIES], bus.cdb_valid, bus.cdb_roben, bus.cdb_data);
   assign {bus.rd2_ready, bus.rd2_data} =
      resolve(bus.rd2_roben, rd2_acc[N_ENTRIES], bus.cdb_valid, bus.cdb_roben, bus.cdb_data);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_reg         <= 5'd1;
         tail_reg         <= 5'd1;
         count_reg        <= 4'd0;
         empty_reg        <= 1'b1;
         full_reg         <= 1'b0;
         commit_wen_reg   <= 1'b0;
         commit_roben_reg <= 5'd0;
         commit_rd_reg    <= 5'd0;
         commit_data_reg  <= 32'd0;
      end else begin
         if (alloc_fire)
            tail_reg <= tail_next;
         if (commit_fire) begin
            head_reg         <= head_next;
            commit_roben_reg <= head_reg;
            commit_rd_reg    <= head_rd;
            commit_data_reg  <= head_data;
         end
         commit_wen_reg <= commit_fire && head_wen;
         count_reg      <= count_next;
         empty_reg      <= (count_next == 4'd0);
         full_reg       <= (count_next == CAPACITY);
      end
   end

   assign bus.alloc_ready  = alloc_ready;
   assign bus.alloc_roben  = tail_reg;
   assign bus.commit_wen   = commit_wen_reg;
   assign bus.commit_roben = commit_roben_reg;
   assign bus.commit_rd    = commit_rd_reg;
   assign bus.commit_data  = commit_data_reg;
   assign bus.empty        = empty_reg;
   assign bus.full         = full_reg;
   assign bus.count        = count_reg;
endmodule
